// File: rtl/epp_bus_ctrl_if.sv
// Signal bundle between the EPP host port, this controller and the downstream block.
// The controller uses the slave view; the host side (or a bench) uses the master view.
interface epp_bus_ctrl_if;
    logic       eppAstb;
    logic       eppDstb;
    logic       eppWr;
    logic [7:0] eppDbIn;
    logic [7:0] eppDbOut;
    logic       eppDbOe;
    logic       eppWait;
    logic [7:0] busEppIn;
    logic [7:0] busEppOut;
    logic [6:0] busEppAdr;
    logic       stbData;
    logic       ctrlWr;
    logic       selBram;
    logic       toErr;

    modport slave (
        input  eppAstb, eppDstb, eppWr, eppDbIn, busEppIn,
        output eppDbOut, eppDbOe, eppWait, busEppOut, busEppAdr,
        output stbData, ctrlWr, selBram, toErr
    );

    modport master (
        output eppAstb, eppDstb, eppWr, eppDbIn, busEppIn,
        input  eppDbOut, eppDbOe, eppWait, busEppOut, busEppAdr,
        input  stbData, ctrlWr, selBram, toErr
    );
endinterface

// File: rtl/epp_bus_ctrl.sv
// EPP slave controller: synchronises host strobes, owns the address register,
// strobes the downstream block for data cycles and runs the host wait handshake.
module epp_bus_ctrl #(
    parameter logic [4:0]  BRAM_BASE   = 5'b00000,
    parameter int unsigned STB_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input logic           clk,
    input logic           rst,
    epp_bus_ctrl_if.slave bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]      STB_INIT = 4'(STB_CYC);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADR_WR,
        ADR_RD,
        DAT_STB,
        DAT_CAP,
        WAIT_REL
    } state_t;

    state_t          state;
    logic [1:0]      astb_sync;
    logic [1:0]      dstb_sync;
    logic [1:0]      wr_sync;
    logic            astb_prev;
    logic            dstb_prev;
    logic            astb_s;
    logic            dstb_s;
    logic            wr_s;
    logic            astb_fall;
    logic            dstb_fall;
    logic            cyc_is_adr;
    logic            cur_strobe_s;
    logic [3:0]      stb_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      db_out;
    logic            db_oe;
    logic            wait_r;
    logic [7:0]      bus_out;
    logic [6:0]      adr;
    logic            stb;
    logic            ctrl_wr;
    logic            to_err;

    // Two-flop synchronisers plus one history flop so only fresh falling edges start a cycle;
    // a strobe still held low after a finished or abandoned cycle is never re-serviced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            astb_sync <= 2'b11;
            dstb_sync <= 2'b11;
            wr_sync   <= 2'b11;
            astb_prev <= 1'b1;
            dstb_prev <= 1'b1;
        end else begin
            astb_sync <= {astb_sync[0], bus.eppAstb};
            dstb_sync <= {dstb_sync[0], bus.eppDstb};
            wr_sync   <= {wr_sync[0], bus.eppWr};
            astb_prev <= astb_sync[1];
            dstb_prev <= dstb_sync[1];
        end
    end

    assign astb_s       = astb_sync[1];
    assign dstb_s       = dstb_sync[1];
    assign wr_s         = wr_sync[1];
    assign astb_fall    = astb_prev & ~astb_s;
    assign dstb_fall    = dstb_prev & ~dstb_s;
    assign cur_strobe_s = cyc_is_adr ? astb_s : dstb_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            db_out     <= 8'h00;
            db_oe      <= 1'b0;
            wait_r     <= 1'b0;
            bus_out    <= 8'h00;
            adr        <= 7'h00;
            stb        <= 1'b0;
            ctrl_wr    <= 1'b1;
            to_err     <= 1'b0;
            stb_cnt    <= 4'd0;
            to_cnt     <= '0;
            cyc_is_adr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (astb_fall) begin
                        cyc_is_adr <= 1'b1;
                        state      <= wr_s ? ADR_RD : ADR_WR;
                    end else if (dstb_fall) begin
                        cyc_is_adr <= 1'b0;
                        ctrl_wr    <= wr_s;
                        if (!wr_s) begin
                            bus_out <= bus.eppDbIn;
                        end
                        stb_cnt <= STB_INIT;
                        stb     <= 1'b1;
                        state   <= DAT_STB;
                    end
                end
                ADR_WR: begin
                    adr    <= bus.eppDbIn[6:0];
                    to_err <= 1'b0;
                    wait_r <= 1'b1;
                    state  <= WAIT_REL;
                end
                ADR_RD: begin
                    db_out <= {1'b0, adr};
                    db_oe  <= 1'b1;
                    wait_r <= 1'b1;
                    state  <= WAIT_REL;
                end
                DAT_STB: begin
                    if (stb_cnt == 4'd1) begin
                        stb   <= 1'b0;
                        state <= DAT_CAP;
                    end else begin
                        stb_cnt <= stb_cnt - 4'd1;
                    end
                end
                DAT_CAP: begin
                    if (ctrl_wr) begin
                        db_out <= bus.busEppIn;
                        db_oe  <= 1'b1;
                    end
                    wait_r <= 1'b1;
                    state  <= WAIT_REL;
                end
                WAIT_REL: begin
                    // A host that never releases its strobe is dropped and flagged.
                    if (cur_strobe_s) begin
                        wait_r <= 1'b0;
                        db_oe  <= 1'b0;
                        state  <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        to_err <= 1'b1;
                        wait_r <= 1'b0;
                        db_oe  <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.eppDbOut  = db_out;
    assign bus.eppDbOe   = db_oe;
    assign bus.eppWait   = wait_r;
    assign bus.busEppOut = bus_out;
    assign bus.busEppAdr = adr;
    assign bus.stbData   = stb;
    assign bus.ctrlWr    = ctrl_wr;
    assign bus.toErr     = to_err;
    assign bus.selBram   = (adr[6:2] == BRAM_BASE);
endmodule

// File: tb/tb_epp_bus_ctrl.sv
// Randomised host-cycle bench for epp_bus_ctrl with a queue-based scoreboard
// fed by the host driver and drained by negedge monitors.
module tb_epp_bus_ctrl;
    localparam int STB_CYC     = 4;
    localparam int TIMEOUT_CYC = 1023;
    localparam int K_ADR_WR    = 0;
    localparam int K_ADR_RD    = 1;
    localparam int K_DAT_WR    = 2;
    localparam int K_DAT_RD    = 3;
    localparam int K_BOTH      = 4;

    typedef struct {
        int         lat;
        logic       oe;
        logic [7:0] dbout;
        logic [6:0] adr;
        logic       sel;
        logic       toerr;
    } rise_t;

    typedef struct {
        logic [7:0] data;
        logic       chk_data;
        logic       wr;
    } stb_t;

    typedef struct {
        logic toerr;
        int   dur;
    } rel_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    epp_bus_ctrl_if bus();

    epp_bus_ctrl #(
        .BRAM_BASE  (5'b00000),
        .STB_CYC    (STB_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    rise_t rise_q[$];
    stb_t  stb_q[$];
    rel_t  rel_q[$];

    logic [6:0] model_adr   = 7'h00;
    logic       model_toerr = 1'b0;

    task automatic check_output(input string name, input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    task automatic wait_level(input logic level, input int budget, input string name);
        int n = 0;
        while (bus.eppWait !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.eppWait !== level) check_output(name, int'(bus.eppWait), int'(level));
    endtask

    // Monitors: wait rise/fall against the handshake queues, stbData pulses against the strobe queue.
    logic  prev_wait = 1'b0;
    logic  in_pulse  = 1'b0;
    int    pulse_len = 0;
    int    wait_len  = 0;
    rise_t mr;
    stb_t  ms;
    rel_t  ml;

    always @(negedge clk) begin
        if (rst) begin
            prev_wait = 1'b0;
            in_pulse  = 1'b0;
            pulse_len = 0;
            wait_len  = 0;
        end else begin
            if (bus.eppWait === 1'b1 && !prev_wait) begin
                if (rise_q.size() == 0) begin
                    check_output("unexpected eppWait", 1, 0);
                end else begin
                    mr = rise_q.pop_front();
                    check_output("wait latency", cyc - start_cyc, mr.lat);
                    check_output("busEppAdr", int'(bus.busEppAdr), int'(mr.adr));
                    check_output("selBram", int'(bus.selBram), int'(mr.sel));
                    check_output("toErr at ack", int'(bus.toErr), int'(mr.toerr));
                    check_output("eppDbOe at ack", int'(bus.eppDbOe), int'(mr.oe));
                    if (mr.oe) check_output("eppDbOut", int'(bus.eppDbOut), int'(mr.dbout));
                end
                wait_len = 0;
            end
            if (bus.eppWait === 1'b1) wait_len++;
            if (bus.eppWait === 1'b0 && prev_wait) begin
                if (rel_q.size() == 0) begin
                    check_output("unexpected release", 1, 0);
                end else begin
                    ml = rel_q.pop_front();
                    check_output("toErr at release", int'(bus.toErr), int'(ml.toerr));
                    if (ml.dur >= 0) check_output("wait duration", wait_len, ml.dur);
                end
                check_output("eppDbOe at release", int'(bus.eppDbOe), 0);
            end
            prev_wait = (bus.eppWait === 1'b1);

            if (bus.stbData === 1'b1 && !in_pulse) begin
                in_pulse  = 1'b1;
                pulse_len = 1;
                if (stb_q.size() == 0) begin
                    check_output("unexpected stbData", 1, 0);
                end else begin
                    ms = stb_q.pop_front();
                    check_output("ctrlWr", int'(bus.ctrlWr), int'(ms.wr));
                    if (ms.chk_data) check_output("busEppOut", int'(bus.busEppOut), int'(ms.data));
                end
            end else if (bus.stbData === 1'b1) begin
                pulse_len++;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                check_output("stbData width", pulse_len, STB_CYC);
            end

            if (bus.eppWr === 1'b0 && (bus.eppAstb === 1'b0 || bus.eppDstb === 1'b0) && bus.eppDbOe !== 1'b0)
                check_output("eppDbOe during write", int'(bus.eppDbOe), 0);
        end
    end

    // One complete host cycle; the reference model and expectations are updated before the strobe falls.
    task automatic apply_stimulus(input int kind, input logic [7:0] d, input logic [7:0] rd, input bit hold_forever);
        rise_t r;
        stb_t  s;
        rel_t  l;
        bit    is_rd;
        bit    is_adr;
        is_rd  = (kind == K_ADR_RD || kind == K_DAT_RD);
        is_adr = (kind == K_ADR_WR || kind == K_ADR_RD || kind == K_BOTH);
        @(posedge clk);
        #1;
        bus.eppWr    = is_rd;
        bus.eppDbIn  = d;
        bus.busEppIn = rd;
        if (kind == K_ADR_WR || kind == K_BOTH) begin
            model_adr   = d[6:0];
            model_toerr = 1'b0;
        end
        r.lat   = is_adr ? 4 : 2 + 1 + STB_CYC + 1;
        r.oe    = is_rd;
        r.dbout = (kind == K_ADR_RD) ? {1'b0, model_adr} : rd;
        r.adr   = model_adr;
        r.sel   = (model_adr < 7'd4);
        r.toerr = model_toerr;
        rise_q.push_back(r);
        if (!is_adr) begin
            s.data     = d;
            s.chk_data = !is_rd;
            s.wr       = is_rd;
            stb_q.push_back(s);
        end
        l.toerr = hold_forever ? 1'b1 : model_toerr;
        l.dur   = hold_forever ? TIMEOUT_CYC : -1;
        rel_q.push_back(l);
        start_cyc = cyc;
        if (is_adr) bus.eppAstb = 1'b0;
        if (!is_adr || kind == K_BOTH) bus.eppDstb = 1'b0;
        wait_level(1'b1, 40, "eppWait rise");
        if (hold_forever) begin
            wait_level(1'b0, TIMEOUT_CYC + 20, "timeout release");
            model_toerr = 1'b1;
            repeat (3) @(negedge clk);
        end else begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.eppAstb = 1'b1;
        bus.eppDstb = 1'b1;
        wait_level(1'b0, 10, "eppWait fall");
        @(negedge clk);
        bus.eppWr = 1'b1;
    endtask

    initial begin
        bus.eppAstb  = 1'b1;
        bus.eppDstb  = 1'b1;
        bus.eppWr    = 1'b1;
        bus.eppDbIn  = 8'h00;
        bus.busEppIn = 8'h00;
        #2 rst = 1'b1;
        #20;
        check_output("reset eppDbOut", int'(bus.eppDbOut), 0);
        check_output("reset eppDbOe", int'(bus.eppDbOe), 0);
        check_output("reset eppWait", int'(bus.eppWait), 0);
        check_output("reset busEppOut", int'(bus.busEppOut), 0);
        check_output("reset busEppAdr", int'(bus.busEppAdr), 0);
        check_output("reset stbData", int'(bus.stbData), 0);
        check_output("reset ctrlWr", int'(bus.ctrlWr), 1);
        check_output("reset selBram", int'(bus.selBram), 1);
        check_output("reset toErr", int'(bus.toErr), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        apply_stimulus(K_ADR_WR, 8'h83, 8'h00, 1'b0);
        apply_stimulus(K_ADR_RD, 8'h00, 8'h00, 1'b0);
        apply_stimulus(K_ADR_WR, 8'h04, 8'h00, 1'b0);
        apply_stimulus(K_DAT_WR, 8'h5A, 8'h00, 1'b0);
        apply_stimulus(K_DAT_RD, 8'h00, 8'hC3, 1'b0);

        // Reset while the downstream strobe is high must clear outputs without a clock edge.
        apply_stimulus(K_ADR_WR, 8'h2B, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        bus.eppWr   = 1'b0;
        bus.eppDbIn = 8'h77;
        stb_q.push_back('{data: 8'h77, chk_data: 1'b1, wr: 1'b0});
        bus.eppDstb = 1'b0;
        begin
            int n = 0;
            while (bus.stbData !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check_output("stbData before reset", int'(bus.stbData), 1);
        end
        #2 rst = 1'b1;
        #1;
        check_output("async reset stbData", int'(bus.stbData), 0);
        check_output("async reset eppWait", int'(bus.eppWait), 0);
        check_output("async reset busEppAdr", int'(bus.busEppAdr), 0);
        check_output("async reset busEppOut", int'(bus.busEppOut), 0);
        bus.eppDstb = 1'b1;
        bus.eppWr   = 1'b1;
        repeat (2) @(negedge clk);
        rise_q.delete();
        stb_q.delete();
        rel_q.delete();
        model_adr   = 7'h00;
        model_toerr = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        apply_stimulus(K_ADR_WR, 8'h11, 8'h00, 1'b0);

        apply_stimulus(K_DAT_WR, 8'hE7, 8'h00, 1'b1);
        apply_stimulus(K_DAT_RD, 8'h00, 8'h3C, 1'b0);
        apply_stimulus(K_ADR_WR, 8'h02, 8'h00, 1'b0);
        apply_stimulus(K_BOTH, 8'hF5, 8'h00, 1'b0);
        apply_stimulus(K_ADR_RD, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 40; i++) begin
            apply_stimulus(int'($urandom_range(0, 4)), 8'($urandom), 8'($urandom), 1'b0);
        end

        repeat (5) @(negedge clk);
        check_output("pending acks", rise_q.size(), 0);
        check_output("pending strobes", stb_q.size(), 0);
        check_output("pending releases", rel_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/epp_bus_ctrl.md
Name: epp_bus_ctrl

Overview:
- Host-side EPP (IEEE-1284 enhanced parallel port) slave controller. It sits directly upstream of the BRAM communication controller.
- Synchronises the asynchronous host strobes and owns the 7-bit EPP address register.
- Decodes the BRAM window and produces the downstream handshake: stbData, ctrlWr, selBram, write data, address.
- Returns downstream read data to the host and drives the EPP wait handshake.

Parameters:
- BRAM_BASE, 5'b00000, value of address bits [6:2] that selects the BRAM window (selBram=1).
- STB_CYC, 4, clk cycles stbData is held high per data cycle (1..15).
- TIMEOUT_CYC, 1023, clk cycles in WAIT_REL before forced return to IDLE (host abandoned cycle).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- eppAstb  in  1  host address strobe, active low, asynchronous
- eppDstb  in  1  host data strobe, active low, asynchronous
- eppWr  in  1  host write, 0=write 1=read, asynchronous
- eppDbIn  in  8  host data bus input
- eppDbOut  out  8  host data bus output
- eppDbOe  out  1  host data bus output enable (1 = drive)
- eppWait  out  1  EPP wait, 1 = cycle acknowledged
- busEppIn  in  8  read data from downstream block
- busEppOut  out  8  write data to downstream block
- busEppAdr  out  7  current EPP address register
- stbData  out  1  data strobe to downstream, active high
- ctrlWr  out  1  downstream write control, 0=write 1=read
- selBram  out  1  BRAM window selected
- toErr  out  1  sticky timeout flag, cleared by the next address write

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - eppDbOut=0, eppDbOe=0, eppWait=0, busEppOut=0, busEppAdr=0, stbData=0, ctrlWr=1, selBram=(BRAM_BASE==0), toErr=0.
  - Synchroniser flops are set to 1 (strobes inactive, eppWr=1).
  - Reset mid-cycle aborts the cycle immediately, and stbData drops in the same instant.
- Input sync:
  - eppAstb, eppDstb and eppWr each pass through a 2-flop synchroniser.
  - The FSM only sees synchronised values.
  - eppDbIn is sampled one cycle after synchronised strobe low (data is stable by then).
- Combinational outputs:
  - selBram = (busEppAdr[6:2]==BRAM_BASE), purely from the register.
  - ctrlWr = registered copy of synced eppWr, latched at cycle start and held until IDLE.
- FSM states: IDLE, ADR_WR, ADR_RD, DAT_STB, DAT_CAP, WAIT_REL.
- IDLE:
  - Astb low has priority over Dstb low if both are seen in the same cycle.
  - Astb low & wr=0 -> ADR_WR. Astb low & wr=1 -> ADR_RD.
  - Dstb low -> DAT_STB; latch ctrlWr, drive busEppOut=eppDbIn on writes, load strobe counter=STB_CYC.
- ADR_WR:
  - busEppAdr <= eppDbIn[6:0]; toErr <= 0; -> WAIT_REL.
  - Bit 7 of the host byte is ignored.
- ADR_RD:
  - eppDbOut <= {1'b0,busEppAdr}; eppDbOe <= 1; -> WAIT_REL.
- DAT_STB:
  - stbData=1; counter decrements each cycle.
  - When counter reaches 1, next cycle stbData=0 and state -> DAT_CAP.
  - stbData is high for exactly STB_CYC cycles. busEppOut and ctrlWr are stable throughout.
- DAT_CAP (one cycle):
  - On reads: eppDbOut <= busEppIn; eppDbOe <= 1.
  - -> WAIT_REL.
- WAIT_REL:
  - eppWait=1, entered the cycle after ADR_WR/ADR_RD/DAT_CAP.
  - When the synced strobe for the current cycle returns high: eppWait=0, eppDbOe=0, -> IDLE.
  - Timeout counter increments while in WAIT_REL. On reaching TIMEOUT_CYC: toErr=1, eppWait=0, eppDbOe=0, -> IDLE.
- eppWait is 0 in every state except WAIT_REL. eppDbOe is never 1 during a host write.
- Host latency, strobe-low to eppWait=1 (synchronised edge):
  - address cycle: 2 sync + 2 clk;
  - data cycle: 2 sync + 1 + STB_CYC + 1 clk.
- A new strobe is not accepted until the previous strobe is released. Back-to-back cycles need the strobe high for at least 1 synced cycle in IDLE.
- Address register does not auto-increment; auto-increment is downstream's job.

Test Plan:
- Reset during DAT_STB with stbData=1 -> stbData=0, eppWait=0, busEppAdr=0 asynchronously; next Astb cycle is accepted normally.
- Address write 0x83 (eppWr=0, Astb low) -> busEppAdr=0x03, selBram=1 (BRAM_BASE=0), eppWait=1 four clocks after Astb falls, drops after Astb rises; read-back address cycle returns eppDbOut=0x03 with eppDbOe=1.
- Address write 0x04 -> selBram=0; data write 0x5A -> busEppOut=0x5A, ctrlWr=0, stbData high exactly 4 clocks, then eppWait=1.
- Data read with busEppIn=0xC3 -> ctrlWr=1, stbData pulse of 4 clocks, eppDbOut=0xC3 and eppDbOe=1 when eppWait rises; eppDbOe=0 after Dstb released.
- Host holds Dstb low indefinitely -> after 1023 clocks in WAIT_REL, toErr=1, eppWait=0, state IDLE; next address write clears toErr.
- Astb and Dstb fall in the same cycle -> address cycle serviced, no stbData pulse.
